// File: rtl/analog_ctrl_driver.sv
`default_nettype none
// ============================================================================
//  Module      : analog_ctrl_driver
//  Description : Buffers control words in a small FIFO and applies them one at
//                a time to the analog control bus. Each apply is announced by
//                a one-cycle strobe and followed by a programmable settle hold
//                that ends with a one-cycle done pulse.
//                Optional macro ANALOG_CTRL_READBACK_EN adds a status capture
//                (status_in -> status_out) taken when the settle period ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module analog_ctrl_driver #(
    parameter int CTRL_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_W   = 8
) (
    input  logic                            clk_in,
    input  logic                            reset_int,
    input  logic [CTRL_W-1:0]               wr_data,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic                            flush,
    input  logic [SETTLE_W-1:0]             settle_cycles,
`ifdef ANALOG_CTRL_READBACK_EN
    input  logic [CTRL_W-1:0]               status_in,
    output logic [CTRL_W-1:0]               status_out,
`endif
    output logic [CTRL_W-1:0]               ctrl_out,
    output logic                            ctrl_strobe,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SETTLE_W-1:0]    cnt_q, cnt_d;
    logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic                   strobe_q, strobe_d;
    logic                   done_q, done_d;

    logic [CTRL_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_settle_exit;

    // Readiness depends only on the stored count, so a pop in the same cycle
    // never opens a slot for a word offered while full.
    assign wr_ready      = (level_q != FULL_LVL);
    assign w_push        = wr_valid && wr_ready;
    // Pop also uses the stored count: a word just pushed is seen one edge later.
    assign w_pop         = (state_q == IDLE) && (level_q != '0);
    assign w_settle_exit = (state_q == SETTLE) && (cnt_q == '0);

    // FIFO pointer/level next state; flush wins over a concurrent push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // FIFO storage; a word offered during flush is dropped.
    always_ff @(posedge clk_in) begin
        if (w_push && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Apply/settle sequencing: pop loads the bus and counter, settle counts down.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_pop) begin
                    state_d  = SETTLE;
                    cnt_d    = settle_cycles;
                    ctrl_d   = mem_q[rd_ptr_q];
                    strobe_d = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, bus and FIFO bookkeeping registers; reset clears everything at once.
    always_ff @(posedge clk_in or posedge reset_int) begin
        if (reset_int) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef ANALOG_CTRL_READBACK_EN
    logic [CTRL_W-1:0] status_q;

    // Snapshot the analog status on the settle-exit edge so it lines up with done.
    always_ff @(posedge clk_in or posedge reset_int) begin
        if (reset_int) begin
            status_q <= '0;
        end else if (w_settle_exit) begin
            status_q <= status_in;
        end
    end

    assign status_out = status_q;
`else
    logic w_unused_exit;
    assign w_unused_exit = w_settle_exit;
`endif

    assign ctrl_out    = ctrl_q;
    assign ctrl_strobe = strobe_q;
    assign busy        = (state_q == SETTLE);
    assign done        = done_q;
    assign fifo_level  = level_q;

endmodule
`default_nettype wire

// File: tb/tb_analog_ctrl_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_analog_ctrl_driver
//  Description : Directed self-checking bench for analog_ctrl_driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_analog_ctrl_driver;

    logic        clk_in = 1'b0;
    logic        reset_int;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        flush;
    logic [7:0]  settle_cycles;
    logic [15:0] ctrl_out;
    logic        ctrl_strobe;
    logic        busy;
    logic        done;
    logic [2:0]  fifo_level;
`ifdef ANALOG_CTRL_READBACK_EN
    logic [15:0] status_in;
    logic [15:0] status_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ns      = 0;
    int nd      = 0;
    int          s_cyc  [32];
    logic [15:0] s_word [32];
    int          d_cyc  [32];
    logic [15:0] words  [5];

    always #5 clk_in = ~clk_in;

    analog_ctrl_driver #(
        .CTRL_W     (16),
        .FIFO_DEPTH (4),
        .SETTLE_W   (8)
    ) dut (
        .clk_in        (clk_in),
        .reset_int     (reset_int),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .flush         (flush),
        .settle_cycles (settle_cycles),
`ifdef ANALOG_CTRL_READBACK_EN
        .status_in     (status_in),
        .status_out    (status_out),
`endif
        .ctrl_out      (ctrl_out),
        .ctrl_strobe   (ctrl_strobe),
        .busy          (busy),
        .done          (done),
        .fifo_level    (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 ns later and log strobe/done events.
    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
        if (ctrl_strobe && ns < 32) begin
            s_cyc[ns]  = cyc;
            s_word[ns] = ctrl_out;
            ns++;
        end
        if (done && nd < 32) begin
            d_cyc[nd] = cyc;
            nd++;
        end
    endtask

    task automatic clear_log();
        ns = 0;
        nd = 0;
    endtask

    initial begin
        reset_int     = 1'b1;
        wr_data       = '0;
        wr_valid      = 1'b0;
        flush         = 1'b0;
        settle_cycles = 8'd0;
`ifdef ANALOG_CTRL_READBACK_EN
        status_in     = '0;
`endif
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;
        words[4] = 16'h5555;

        // ---------------- reset state ----------------
        @(posedge clk_in);
        #1;
        chk("rst_ctrl_out",   32'(ctrl_out),    32'h0);
        chk("rst_strobe",     32'(ctrl_strobe), 32'h0);
        chk("rst_done",       32'(done),        32'h0);
        chk("rst_busy",       32'(busy),        32'h0);
        chk("rst_level",      32'(fifo_level),  32'h0);
        chk("rst_wr_ready",   32'(wr_ready),    32'h1);
`ifdef ANALOG_CTRL_READBACK_EN
        chk("rst_status_out", 32'(status_out),  32'h0);
`endif
        @(posedge clk_in);
        #1;
        reset_int = 1'b0;
        step();

        // ---------------- single word, settle=3 ----------------
        settle_cycles = 8'd3;
        wr_data  = 16'hA5A5;
        wr_valid = 1'b1;
        step();                         // push edge
        wr_valid = 1'b0;
        chk("t1_level_after_push", 32'(fifo_level),  32'h1);
        chk("t1_no_strobe_yet",    32'(ctrl_strobe), 32'h0);
        step();                         // pop edge T
        chk("t1_strobe",           32'(ctrl_strobe), 32'h1);
        chk("t1_ctrl_out",         32'(ctrl_out),    32'hA5A5);
        chk("t1_busy",             32'(busy),        32'h1);
        chk("t1_level_after_pop",  32'(fifo_level),  32'h0);
        step();                         // T+1
        chk("t1_strobe_one_cycle", 32'(ctrl_strobe), 32'h0);
        step();
        step();
        chk("t1_done_early",       32'(done),        32'h0);
        step();                         // T+4 edge: settle exits
        chk("t1_done",             32'(done),        32'h1);
        chk("t1_busy_falls",       32'(busy),        32'h0);
        step();
        chk("t1_done_one_cycle",   32'(done),        32'h0);
        chk("t1_ctrl_hold",        32'(ctrl_out),    32'hA5A5);

        // ---------------- five words, settle=10 ----------------
        clear_log();
        settle_cycles = 8'd10;
        wr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_data = words[k];
            step();                     // P1..P5, W0 popped at P2
        end
        chk("t2_level_full",       32'(fifo_level),  32'h4);
        chk("t2_wr_ready_low",     32'(wr_ready),    32'h0);
        wr_data = 16'hDEAD;             // offered while full, must be refused
        for (int k = 0; k < 9; k++) step();   // P6..P14, pop of W1 at P14
        chk("t2_refused_on_pop",   32'(fifo_level),  32'h3);
        chk("t2_ready_again",      32'(wr_ready),    32'h1);
        wr_valid = 1'b0;
        for (int k = 0; k < 48; k++) step();  // through last done at P61
        chk("t2_level_empty",      32'(fifo_level),  32'h0);
        chk("t2_idle",             32'(busy),        32'h0);
        chk("t2_strobe_count",     32'(ns),          32'd5);
        chk("t2_done_count",       32'(nd),          32'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_word%0d", k), 32'(s_word[k]), 32'(words[k]));
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_gap%0d", k), 32'(s_cyc[k+1] - s_cyc[k]), 32'd12);
        end
        chk("t2_last_done_lat",    32'(d_cyc[4] - s_cyc[4]), 32'd11);

        // ---------------- settle=0, two words ----------------
        clear_log();
        settle_cycles = 8'd0;
        wr_valid = 1'b1;
        wr_data  = 16'h0101;
        step();
        wr_data  = 16'h0202;
        step();
        wr_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("t3_strobe_count",     32'(ns),          32'd2);
        chk("t3_done_count",       32'(nd),          32'd2);
        chk("t3_gap",              32'(s_cyc[1] - s_cyc[0]), 32'd2);
        chk("t3_done_before_2nd",  32'(s_cyc[1] - d_cyc[0]), 32'd1);
        chk("t3_word0",            32'(s_word[0]),   32'h0101);
        chk("t3_word1",            32'(s_word[1]),   32'h0202);

        // ---------------- flush during settle ----------------
        clear_log();
        settle_cycles = 8'd5;
        wr_valid = 1'b1;
        wr_data  = 16'hAAA0;
        step();
        wr_data  = 16'hAAA1;
        step();                         // pop of AAA0
        wr_data  = 16'hAAA2;
        step();
        chk("t4_level_before",     32'(fifo_level),  32'h2);
        flush   = 1'b1;
        wr_data = 16'h7777;             // dropped: flush wins
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        chk("t4_level_flushed",    32'(fifo_level),  32'h0);
        chk("t4_still_busy",       32'(busy),        32'h1);
        for (int k = 0; k < 11; k++) step();
        chk("t4_strobe_count",     32'(ns),          32'd1);
        chk("t4_done_count",       32'(nd),          32'd1);
        chk("t4_ctrl_out",         32'(ctrl_out),    32'hAAA0);
        chk("t4_level_end",        32'(fifo_level),  32'h0);

        // ---------------- pop in the same cycle as flush ----------------
        settle_cycles = 8'd0;
        wr_valid = 1'b1;
        wr_data  = 16'h9999;
        step();
        wr_valid = 1'b0;
        flush    = 1'b1;
        step();                         // pop + flush together
        flush    = 1'b0;
        chk("t4b_strobe",          32'(ctrl_strobe), 32'h1);
        chk("t4b_ctrl_out",        32'(ctrl_out),    32'h9999);
        chk("t4b_level",           32'(fifo_level),  32'h0);
        step();
        chk("t4b_done",            32'(done),        32'h1);
        step();

        // ---------------- reset mid-settle ----------------
        settle_cycles = 8'd20;
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        step();
        wr_data  = 16'h5678;
        step();                         // 1234 applied, 5678 buffered
        wr_valid = 1'b0;
        step();
        step();
        chk("t5_pre_ctrl",         32'(ctrl_out),    32'h1234);
        chk("t5_pre_level",        32'(fifo_level),  32'h1);
        clear_log();
        reset_int = 1'b1;
        #1;
        chk("t5_rst_ctrl",         32'(ctrl_out),    32'h0);
        chk("t5_rst_busy",         32'(busy),        32'h0);
        chk("t5_rst_level",        32'(fifo_level),  32'h0);
        step();
        step();
        reset_int = 1'b0;
        for (int k = 0; k < 25; k++) step();
        chk("t5_no_done",          32'(nd),          32'd0);
        chk("t5_no_strobe",        32'(ns),          32'd0);
        chk("t5_ctrl_zero",        32'(ctrl_out),    32'h0);

`ifdef ANALOG_CTRL_READBACK_EN
        // ---------------- status readback ----------------
        settle_cycles = 8'd3;
        status_in = 16'h00FF;
        wr_valid  = 1'b1;
        wr_data   = 16'h4242;
        step();
        wr_valid  = 1'b0;
        step();                         // pop edge T
        step();
        step();
        step();                         // T+3: counter reaches 0
        status_in = 16'hBEEF;
        step();                         // T+4: settle exit captures status
        chk("rb_done",             32'(done),        32'h1);
        chk("rb_status",           32'(status_out),  32'hBEEF);
        status_in = 16'h0000;
        step();
        chk("rb_status_hold",      32'(status_out),  32'hBEEF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/analog_ctrl_driver.md
Name: analog_ctrl_driver

Overview:
- Digital-side driver for the analog block's 16-bit control bus.
- Accepts control words from the student subsystem register logic over a valid/ready interface and buffers them in a small FIFO.
- Applies one word at a time to the analog control bus with a one-cycle strobe, then holds it for a programmable settle time before signalling completion.
- Sits between the student subsystem register/pmod logic and the analog block's control input.

Parameters:
- CTRL_W, 16, control word width; matches the analog block control bus.
- FIFO_DEPTH, 4, number of buffered control words; power of two, minimum 2.
- SETTLE_W, 8, width of the settle-time counter.

Ports:
- clk_in  input  1  system clock.
- reset_int  input  1  asynchronous, active-high reset.
- wr_data  input  CTRL_W  control word to enqueue.
- wr_valid  input  1  wr_data is valid.
- wr_ready  output  1  FIFO can accept a word.
- flush  input  1  synchronous FIFO clear.
- settle_cycles  input  SETTLE_W  hold time after each apply, in cycles.
- ctrl_out  output  CTRL_W  registered control bus to the analog block.
- ctrl_strobe  output  1  one-cycle pulse when ctrl_out changes.
- busy  output  1  FSM is not in IDLE.
- done  output  1  one-cycle pulse when the settle time has elapsed.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words stored.

Behaviour:
- Reset values (async, immediate): ctrl_out=0, ctrl_strobe=0, done=0, busy=0, fifo_level=0, FSM=IDLE, counter=0. wr_ready=1 once the FIFO is empty.
- Push and wr_ready:
  - A push occurs on a rising edge with wr_valid && wr_ready.
  - wr_ready = (fifo_level != FIFO_DEPTH), purely from the stored count. While full, a push is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves fifo_level unchanged.
- FSM states: IDLE, SETTLE.
- IDLE:
  - If the FIFO is non-empty at edge T, pop the head word.
  - At T+1: ctrl_out=word, ctrl_strobe=1 for one cycle, FSM=SETTLE, counter=settle_cycles sampled at edge T.
  - A word pushed into an empty FIFO at edge T is popped no earlier than edge T+1.
- SETTLE:
  - Counter decrements by 1 on each edge while non-zero.
  - At the edge where counter==0: FSM=IDLE and done=1 for exactly one cycle.
  - With settle_cycles=N, done is high in cycle T+2+N relative to the pop edge T.
  - A pending word may be popped in the same IDLE cycle in which done is high, so consecutive strobes are N+2 cycles apart.
- busy=1 while FSM==SETTLE.
- ctrl_out holds its last value indefinitely in IDLE. It changes only with ctrl_strobe.
- settle_cycles changes during SETTLE have no effect until the next pop.
- flush:
  - Synchronous; sets fifo_level=0 and pointers=0 on the next edge.
  - Does not affect FSM, counter, or ctrl_out; an in-progress settle completes normally.
  - flush has priority over a simultaneous push; that word is dropped.
  - A pop in the same cycle as flush still completes and that word is applied.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by fifo_level.
- Reset mid-settle aborts immediately: done is not pulsed and ctrl_out returns to 0.

Optional Feature:
- Macro: ANALOG_CTRL_READBACK_EN.
- Defined: adds input status_in[CTRL_W] and output status_out[CTRL_W], reset value 0.
  - status_out captures status_in at the edge where SETTLE exits, so it is valid in the same cycle done is high.
  - status_out holds that value until the next capture.
- Undefined: these ports do not exist and no capture registers are built.

Test Plan:
- Reset then push 0xA5A5 with settle_cycles=3 -> ctrl_strobe one cycle after the pop with ctrl_out=0xA5A5; done pulses 5 cycles after the pop edge; busy falls with done.
- Push 5 words back-to-back with FIFO_DEPTH=4 and settle_cycles=10 -> wr_ready drops after 4 buffered words (the first word is popped, so the 5th is accepted once space frees); all 5 words are applied in order with strobes 12 cycles apart.
- settle_cycles=0, two words queued -> strobes 2 cycles apart; done high in the cycle before the second strobe.
- Queue 3 words, assert flush during the first settle -> first word completes with done; no further strobes; fifo_level=0.
- Assert reset_int mid-settle with ctrl_out=0x1234 -> ctrl_out=0, busy=0, fifo_level=0 immediately; no done pulse.
- With ANALOG_CTRL_READBACK_EN: status_in=0x00FF during settle and 0xBEEF at the last settle edge -> status_out=0xBEEF in the done cycle.
